// File: rtl/frame_compositor.sv
// rtl/frame_compositor.sv - layer merge to 12-bit RGB, per-frame collision decision, BCD score
module frame_compositor #(
  parameter logic [11:0] BG_COLOR     = 12'hFFF,
  parameter logic [11:0] DINO_COLOR   = 12'h333,
  parameter logic [11:0] CACTUS_COLOR = 12'h070,
  parameter logic [11:0] GROUND_COLOR = 12'h555,
  parameter int unsigned HIT_MIN      = 4,
  parameter int unsigned SCORE_DIV    = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fresh,
  input  logic        video_on,
  input  logic        game_status,
  input  logic        dino_px,
  input  logic        cactus_px,
  input  logic        ground_px,
  output logic [11:0] rgb,
  output logic        game_over,
  output logic        collision,
  output logic [15:0] score
);

  localparam logic [7:0] HIT_MIN_W = 8'(HIT_MIN);
  localparam logic [7:0] DIV_LAST  = 8'(SCORE_DIV - 1);

  logic        fresh_q;
  logic        gs_q;
  logic [7:0]  hit_cnt;
  logic [7:0]  div_cnt;
  logic        frame_end;
  logic        restart;
  logic        overlap;
  logic        hit_now;
  logic        score_tick;
  logic [11:0] pix_color;
  logic [15:0] score_inc;
  logic        carry;

  always_comb begin
    frame_end  = fresh_q & ~fresh;
    restart    = game_status & ~gs_q;
    overlap    = dino_px & cactus_px & video_on & game_status & ~game_over;
    hit_now    = frame_end & ~game_over & (hit_cnt >= HIT_MIN_W);
    // a frame that ends the game earns no score
    score_tick = frame_end & game_status & ~game_over & ~hit_now;
  end

  always_comb begin
    pix_color = BG_COLOR;
    if (dino_px)
      pix_color = DINO_COLOR;
    else if (cactus_px)
      pix_color = CACTUS_COLOR;
    else if (ground_px)
      pix_color = GROUND_COLOR;
    if (game_over)
      pix_color = ~pix_color;
    if (!video_on)
      pix_color = '0;
  end

  // ripple BCD +1, pinned at 9999
  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (score == 16'h9999)
      score_inc = score;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fresh_q   <= 1'b0;
      gs_q      <= 1'b0;
      rgb       <= '0;
      game_over <= 1'b0;
      collision <= 1'b0;
      score     <= '0;
      hit_cnt   <= '0;
      div_cnt   <= '0;
    end else begin
      fresh_q   <= fresh;
      gs_q      <= game_status;
      rgb       <= pix_color;
      collision <= 1'b0;
      if (restart) begin
        game_over <= 1'b0;
        score     <= '0;
        div_cnt   <= '0;
        hit_cnt   <= '0;
      end else begin
        if (hit_now) begin
          game_over <= 1'b1;
          collision <= 1'b1;
        end
        // the overlap on the boundary cycle belongs to the new frame
        if (frame_end)
          hit_cnt <= {7'd0, overlap};
        else if (overlap && hit_cnt != 8'hFF)
          hit_cnt <= hit_cnt + 8'd1;
        if (score_tick) begin
          if (div_cnt >= DIV_LAST) begin
            div_cnt <= '0;
            score   <= score_inc;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_compositor.sv
// tb/tb_frame_compositor.sv - self-checking bench for frame_compositor
module tb_frame_compositor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fresh = 1'b0, von = 1'b0, gs = 1'b0, dino = 1'b0, cactus = 1'b0, ground = 1'b0;
  logic fresh2 = 1'b0;
  logic [11:0] rgb, rgb2;
  logic        game_over, collision, game_over2, collision2;
  logic [15:0] score, score2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  frame_compositor dut (
    .CLK(clk), .RESET(reset), .fresh(fresh), .video_on(von), .game_status(gs),
    .dino_px(dino), .cactus_px(cactus), .ground_px(ground),
    .rgb(rgb), .game_over(game_over), .collision(collision), .score(score)
  );

  // one score step per frame so saturation is reachable quickly
  frame_compositor #(.SCORE_DIV(1)) dut2 (
    .CLK(clk), .RESET(reset), .fresh(fresh2), .video_on(1'b1), .game_status(1'b1),
    .dino_px(1'b0), .cactus_px(1'b0), .ground_px(1'b0),
    .rgb(rgb2), .game_over(game_over2), .collision(collision2), .score(score2)
  );

  // reference model: counts overlap pixels per frame and scoring frames since restart
  logic [11:0] m_rgb = '0;
  logic        m_go = 1'b0, m_col = 1'b0, m_prev_fresh = 1'b0, m_prev_gs = 1'b0;
  int          m_frame_hits = 0;
  int          m_scored_frames = 0;

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] exp_score();
    return to_bcd(m_scored_frames / 6);
  endfunction

  always @(posedge clk) begin
    logic fe, rs, ov, ends_game;
    logic [11:0] c;
    if (reset) begin
      m_rgb <= '0; m_go <= 1'b0; m_col <= 1'b0;
      m_prev_fresh <= 1'b0; m_prev_gs <= 1'b0;
      m_frame_hits <= 0; m_scored_frames <= 0;
    end else begin
      fe = m_prev_fresh && !fresh;
      rs = gs && !m_prev_gs;
      ov = dino && cactus && von && gs && !m_go;
      if (!von) c = 12'h000;
      else begin
        c = dino ? 12'h333 : cactus ? 12'h070 : ground ? 12'h555 : 12'hFFF;
        if (m_go) c = ~c;
      end
      m_rgb <= c;
      m_prev_fresh <= fresh;
      m_prev_gs <= gs;
      m_col <= 1'b0;
      if (rs) begin
        m_go <= 1'b0; m_frame_hits <= 0; m_scored_frames <= 0;
      end else begin
        ends_game = fe && !m_go && m_frame_hits >= 4;
        if (ends_game) begin m_go <= 1'b1; m_col <= 1'b1; end
        if (fe) m_frame_hits <= ov ? 1 : 0;
        else if (ov) m_frame_hits <= (m_frame_hits < 255) ? m_frame_hits + 1 : 255;
        if (fe && gs && !m_go && !ends_game) m_scored_frames <= m_scored_frames + 1;
      end
    end
  end

  task automatic drive(input logic f, input logic v, input logic g,
                       input logic d, input logic c, input logic gr);
    fresh = f; von = v; gs = g; dino = d; cactus = c; ground = gr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h exp %h", rgb, 12'h000); else n_pass++;
    n_checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b exp 0", game_over); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL reset_collision: got %b exp 0", collision); else n_pass++;
    n_checks++; if (score !== 16'h0000) $display("FAIL reset_score: got %h exp 0000", score); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_colors();
    logic [2:0] b;
    logic [11:0] e;
    for (int i = 0; i < 8; i++) begin
      b = 3'(i);
      e = b[2] ? 12'h333 : b[1] ? 12'h070 : b[0] ? 12'h555 : 12'hFFF;
      drive(1'b0, 1'b1, 1'b0, b[2], b[1], b[0]);
      n_checks++; if (rgb !== e) $display("FAIL color_%0d: got %h exp %h", i, rgb, e); else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++; if (rgb !== 12'h000) $display("FAIL color_blank: got %h exp 000", rgb); else n_pass++;
  endtask

  task automatic do_restart();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic overlaps(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic clean_frame_end();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_threshold();
    do_restart();
    overlaps(3);
    clean_frame_end();
    n_checks++; if (game_over !== 1'b0) $display("FAIL thr_below: got %b exp 0", game_over); else n_pass++;
    overlaps(4);
    clean_frame_end();
    n_checks++; if (collision !== 1'b1) $display("FAIL thr_pulse: got %b exp 1", collision); else n_pass++;
    n_checks++; if (game_over !== 1'b1) $display("FAIL thr_game_over: got %b exp 1", game_over); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (collision !== 1'b0) $display("FAIL thr_pulse_width: got %b exp 0", collision); else n_pass++;
    n_checks++; if (rgb !== 12'h000) $display("FAIL thr_inverted_bg: got %h exp 000", rgb); else n_pass++;
    overlaps(5);
    clean_frame_end();
    n_checks++; if (collision !== 1'b0) $display("FAIL thr_no_repulse: got %b exp 0", collision); else n_pass++;
  endtask

  task automatic test_score();
    do_restart();
    for (int i = 0; i < 60; i++) clean_frame_end();
    n_checks++; if (score !== 16'h0010) $display("FAIL score_60: got %h exp 0010", score); else n_pass++;
  endtask

  task automatic test_carry_pixel();
    do_restart();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    overlaps(3);
    clean_frame_end();
    n_checks++; if (game_over !== 1'b1) $display("FAIL carry_pixel: got %b exp 1", game_over); else n_pass++;
  endtask

  task automatic test_collision_on_score_frame();
    do_restart();
    for (int i = 0; i < 5; i++) clean_frame_end();
    overlaps(4);
    clean_frame_end();
    n_checks++; if (game_over !== 1'b1) $display("FAIL coll_score_go: got %b exp 1", game_over); else n_pass++;
    n_checks++; if (score !== 16'h0000) $display("FAIL coll_score_held: got %h exp 0000", score); else n_pass++;
  endtask

  task automatic test_restart();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (game_over !== 1'b0) $display("FAIL restart_go: got %b exp 0", game_over); else n_pass++;
    n_checks++; if (score !== 16'h0000) $display("FAIL restart_score: got %h exp 0000", score); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL restart_col: got %b exp 0", collision); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (collision !== 1'b0) $display("FAIL restart_col2: got %b exp 0", collision); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    do_restart();
    for (int i = 0; i < 6; i++) clean_frame_end();
    overlaps(3);
    reset = 1'b1;
    overlaps(1);
    n_checks++; if (rgb !== 12'h000) $display("FAIL rst_mid_rgb: got %h exp 000", rgb); else n_pass++;
    n_checks++; if (score !== 16'h0000) $display("FAIL rst_mid_score: got %h exp 0000", score); else n_pass++;
    n_checks++; if (game_over !== 1'b0 || collision !== 1'b0)
      $display("FAIL rst_mid_flags: got go=%b col=%b exp 0 0", game_over, collision); else n_pass++;
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    overlaps(3);
    clean_frame_end();
    n_checks++; if (game_over !== 1'b0) $display("FAIL rst_mid_next_frame: got %b exp 0", game_over); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9998; i++) begin
      fresh2 = 1'b1; @(negedge clk);
      fresh2 = 1'b0; @(negedge clk);
    end
    n_checks++; if (score2 !== 16'h9998) $display("FAIL sat_9998: got %h exp 9998", score2); else n_pass++;
    fresh2 = 1'b1; @(negedge clk);
    fresh2 = 1'b0; @(negedge clk);
    n_checks++; if (score2 !== 16'h9999) $display("FAIL sat_9999: got %h exp 9999", score2); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      fresh2 = 1'b1; @(negedge clk);
      fresh2 = 1'b0; @(negedge clk);
    end
    n_checks++; if (score2 !== 16'h9999) $display("FAIL sat_hold: got %h exp 9999", score2); else n_pass++;
    n_checks++; if (rgb2 !== 12'hFFF || game_over2 !== 1'b0 || collision2 !== 1'b0)
      $display("FAIL sat_side: got rgb=%h go=%b col=%b exp FFF 0 0", rgb2, game_over2, collision2); else n_pass++;
  endtask

  task automatic test_random();
    logic g;
    int errs;
    g = 1'b1;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) g = ~g;
      drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0), g,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (rgb !== m_rgb || game_over !== m_go || collision !== m_col || score !== exp_score()) begin
        if (errs < 10)
          $display("FAIL random_%0d: got rgb=%h go=%b col=%b score=%h exp rgb=%h go=%b col=%b score=%h",
                   i, rgb, game_over, collision, score, m_rgb, m_go, m_col, exp_score());
        errs++;
      end else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_colors();
    test_threshold();
    test_score();
    test_carry_pixel();
    test_collision_on_score_frame();
    test_restart();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
